ff_cmd_arbiter: RTL

Round-robin arbiter that shares one bank of T flip-flops between several requesters. Each requester issues a set, reset, toggle or hold command against one bit of the bank. The block serialises these commands, converts the winning command into a single-bit T drive, and returns a one-cycle grant. It sits between control-side requesters and the team's T-flip-flop storage primitives.

---
 rtl/ff_arb_pkg.sv | 15 +
 rtl/tff_bank.sv | 29 ++
 rtl/ff_cmd_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ff_arb_pkg.sv
// ff_arb_pkg: command encodings and FSM state type shared by the
// T-flip-flop command arbiter and its bank.
package ff_arb_pkg;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_SET  = 2'b01;
    localparam logic [1:0] CMD_RST  = 2'b10;
    localparam logic [1:0] CMD_TGL  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tff_bank.sv
// tff_bank: WIDTH independent T flip-flops sharing clock and
// asynchronous active-low reset; a bit flips when its t is high.
module tff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ff_cmd_arbiter.sv
// ff_cmd_arbiter: serialises set/reset/toggle/hold commands onto a
// T-flip-flop bank. FF_ARB_FIXED_PRIO_EN selects fixed priority.
module ff_cmd_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [NREQ-1:0]               req,
    input  logic [2*NREQ-1:0]             cmd,
    input  logic [NREQ*$clog2(WIDTH)-1:0] idx,
    output logic [NREQ-1:0]               gnt,
    output logic [WIDTH-1:0]              q,
    output logic                          busy
);

    import ff_arb_pkg::*;

    localparam int IW = $clog2(WIDTH);
    localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [WW-1:0]   win_q, win_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WW-1:0]   pick;
    logic            found;
    logic [WIDTH-1:0] t;
    logic            cur;
    logic            want;

`ifdef FF_ARB_FIXED_PRIO_EN
    always_comb begin : arb_sel
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                pick  = WW'(i);
            end
        end
    end
`else
    logic [WW-1:0] ptr_q, ptr_d;

    // Search starts one past the last winner and wraps.
    always_comb begin : arb_sel
        int k;
        k     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(ptr_q) + i) % NREQ;
            if (!found && req[k]) begin
                found = 1'b1;
                pick  = WW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
`ifndef FF_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    cmd_d   = cmd[2*int'(pick) +: 2];
                    idx_d   = idx[int'(pick)*IW +: IW];
                    state_d = APPLY;
                end
            end
            APPLY: begin
`ifndef FF_ARB_FIXED_PRIO_EN
                ptr_d   = win_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            win_q   <= '0;
            cmd_q   <= '0;
            idx_q   <= '0;
`ifndef FF_ARB_FIXED_PRIO_EN
            ptr_q   <= WW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
`ifndef FF_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign busy = (state_q == APPLY);

    always_comb begin
        gnt = '0;
        if (busy) begin
            gnt[win_q] = 1'b1;
        end
    end

    // Out-of-range targets leave t all zero, so the bank holds.
    always_comb begin
        t    = '0;
        cur  = 1'b0;
        want = 1'b0;
        if (busy && (int'(idx_q) < WIDTH)) begin
            cur = q[idx_q];
            unique case (cmd_q)
                CMD_SET:  want = 1'b1;
                CMD_RST:  want = 1'b0;
                CMD_TGL:  want = ~cur;
                default:  want = cur;
            endcase
            t[idx_q] = cur ^ want;
        end
    end

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk(clk),
        .res(res),
        .t  (t),
        .q  (q)
    );

endmodule
